// File: rtl/mem2_load_resp.sv
// MEM2-stage load response tracker: waits for the DCache read of the load in MEM2,
// aligns/extends its data, holds it until the instruction leaves, and discards late responses of flushed loads.
module mem2_load_resp #(
  parameter int DROP_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM2_Wr,
  input  logic        MEM2_Flush,
  input  logic        MEM_LoadReq,
  input  logic [1:0]  MEM2_Addr,
  input  logic [1:0]  MEM2_LoadSize,
  input  logic        MEM2_LoadSign,
  input  logic        DCache_RValid,
  input  logic [31:0] DCache_RData,
  input  logic        WB_Wr,
  output logic [31:0] MEM2_LoadData,
  output logic        MEM2_LoadValid,
  output logic        MEM2_DCacheStall,
  output logic        MEM2_RespErr
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  state_t            state, state_nxt;
  logic [DROP_W-1:0] drop_cnt, drop_nxt;
  logic [31:0]       hold_data, aligned;
  logic              err, err_nxt;
  logic              capture, matched, drop_resp, drop_inc;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // Leaving MEM2 is signalled by MEM2_Wr/MEM2_Flush, so WB acceptance carries no information here.
  logic unused_wb;
  assign unused_wb = WB_Wr;

  always_comb begin
    byte_sel = DCache_RData[{MEM2_Addr, 3'b000} +: 8];
    half_sel = MEM2_Addr[1] ? DCache_RData[31:16] : DCache_RData[15:0];
    case (MEM2_LoadSize)
      2'd0:    aligned = {{24{MEM2_LoadSign & byte_sel[7]}}, byte_sel};
      2'd1:    aligned = {{16{MEM2_LoadSign & half_sel[15]}}, half_sel};
      default: aligned = DCache_RData;
    endcase
  end

  // Responses are in order: while drop_cnt is nonzero the head response belongs to a flushed load.
  assign matched   = DCache_RValid && (drop_cnt == '0) && (state == WAIT);
  assign drop_resp = DCache_RValid && (drop_cnt != '0);
  assign drop_inc  = MEM2_Flush && (state == WAIT) && !matched;

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_cnt;
    err_nxt   = err | (DCache_RValid && (drop_cnt == '0) && (state != WAIT));
    capture   = 1'b0;
    if (drop_inc && !drop_resp) begin
      if (drop_cnt == DROP_MAX) err_nxt = 1'b1;
      else                      drop_nxt = drop_cnt + 1'b1;
    end else if (drop_resp && !drop_inc) begin
      drop_nxt = drop_cnt - 1'b1;
    end
    if (MEM2_Flush) begin
      state_nxt = IDLE;
    end else if (MEM2_Wr) begin
      state_nxt = MEM_LoadReq ? WAIT : IDLE;
    end else if (matched) begin
      state_nxt = HOLD;
      capture   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drop_cnt  <= '0;
      hold_data <= '0;
      err       <= 1'b0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
      err      <= err_nxt;
      if (capture) hold_data <= aligned;
    end
  end

  // A response matched in a flush cycle is swallowed, so the flushed load never reports valid data.
  assign MEM2_LoadValid   = (state == HOLD) || (matched && !MEM2_Flush);
  assign MEM2_LoadData    = (state == HOLD) ? hold_data :
                            (matched && !MEM2_Flush) ? aligned : 32'd0;
  assign MEM2_DCacheStall = (state == WAIT) && !matched && !MEM2_Flush;
  assign MEM2_RespErr     = err;

endmodule
